game_start_sequencer: RTL
=========================

// Module: game_start_sequencer
// PURPOSE
//   Drives the loading-screen renderer. Decodes the OLED driver's linear pixel_index
//   into registered (x,y) coordinates. Steps the loading-bar counter cnt from 1 to
//   NUM_STEPS at a fixed frame cadence, then holds on the full bar. Signals the game
//   FSM when the loading screen is finished. Sits between the OLED driver and the
//   renderer; done feeds the top-level game FSM.
// PARAMETERS
//   WIDTH            96   display columns
//   HEIGHT           64   display rows
//   NUM_STEPS        4    loading-bar segments (cnt runs 1..NUM_STEPS)
//   FRAMES_PER_STEP  30   frames each segment is shown, >=1
//   HOLD_FRAMES      15   frames the last segment stays shown before done, >=1
// PORTS
//   clk          in   1    system clock
//   rst_n        in   1    asynchronous active-low reset
//   pixel_index  in   13   linear pixel index from OLED driver, row-major
//   frame_begin  in   1    1-cycle pulse from OLED driver at start of each frame
//   start        in   1    1-cycle request to begin the loading sequence
//   skip         in   1    1-cycle request to abort to done (debounced upstream)
//   x            out  7    column = pixel_index % WIDTH, registered
//   y            out  6    row = pixel_index / WIDTH, registered
//   pix_valid    out  1    registered; 1 when pixel_index < WIDTH*HEIGHT
//   cnt          out  3    loading-bar step to the renderer; 0 = no bar lit
//   busy         out  1    1 in LOAD or HOLD
//   done         out  1    1-cycle pulse when the sequence ends
// BEHAVIOUR
//   Reset (async, rst_n=0): x=0, y=0, pix_valid=0, cnt=0, busy=0, done=0, state=IDLE,
//     frame counter=0. A reset mid-sequence aborts immediately with no done pulse.
//   Coordinate path: x, y and pix_valid update on the cycle after pixel_index
//     (1-cycle latency). An out-of-range index (>=6144 at default size) gives x=0, y=0,
//     pix_valid=0. Division uses constant arithmetic only; no generic divider.
//   FSM states: IDLE, LOAD, HOLD, DONE.
//   IDLE: cnt=0. On start, next cycle: state=LOAD, cnt=1, fcnt=0, busy=1.
//     skip is ignored in IDLE.
//   LOAD: on each frame_begin, fcnt++. A frame_begin with fcnt==FRAMES_PER_STEP-1
//     clears fcnt and then:
//     - if cnt<NUM_STEPS: cnt++;
//     - if cnt==NUM_STEPS: state=HOLD (cnt stays NUM_STEPS).
//   HOLD: counts HOLD_FRAMES frame_begin pulses in fcnt. On the last one: state=DONE.
//   DONE: lasts exactly one cycle. done=1, busy=0, cnt=0; next state=IDLE.
//   skip in LOAD or HOLD: the next state is DONE, regardless of frame_begin in the
//     same cycle.
//   start while busy or in DONE: ignored, and the counters are not restarted.
//   start and skip in the same cycle in IDLE: start is taken.
//   fcnt width is clog2(max(FRAMES_PER_STEP,HOLD_FRAMES)). It never wraps past its
//     terminal value.
//   All outputs are registered. No combinational path runs from any input to any output.
// STRUCTURE
//   Shared game package: colour constants, WIDTH/HEIGHT, sequencer state encoding
//     (2-bit enum).
//   Sub-module pixel_xy_decode: pixel_index -> registered x, y, pix_valid. The OLED
//     game screens reuse it.
//   The FSM and frame counter stay in this module.
// TESTING (bench parameters: FRAMES_PER_STEP=2, HOLD_FRAMES=3)
//   pixel_index=0, 95, 96, 6143, 6144 -> one cycle later (x,y,pix_valid) =
//     (0,0,1), (95,0,1), (0,1,1), (95,63,1), (0,0,0).
//   start pulse, then 11 frame_begin pulses -> cnt steps 1,2,3,4 on frame_begin
//     #2, #4, #6; HOLD is entered on #8; done pulses exactly once on the cycle after
//     #11; cnt=0 after done.
//   skip while cnt=2 -> next cycle done=1, busy=0, cnt=0; no further cnt change.
//   Second start while busy (cnt=3) -> sequence timing unchanged and only one done.
//   rst_n low while cnt=3 -> cnt=0 and busy=0 immediately (asynchronous), no done;
//     a start after release restarts at cnt=1.
//   start and skip in the same cycle in IDLE -> LOAD with cnt=1; skip in IDLE alone
//     -> no done.

Source files
------------

// File: rtl/game_start_sequencer_pkg.sv
// Shared definitions for the game screens: display geometry, colours and the
// loading-screen sequencer state encoding.
package game_start_sequencer_pkg;

  localparam int unsigned ScreenWidth  = 96;
  localparam int unsigned ScreenHeight = 64;
  localparam int unsigned PixelIdxW    = 13;

  // RGB565 colours used by the renderers
  localparam logic [15:0] ColBlack = 16'h0000;
  localparam logic [15:0] ColWhite = 16'hFFFF;
  localparam logic [15:0] ColRed   = 16'hF800;
  localparam logic [15:0] ColGreen = 16'h07E0;
  localparam logic [15:0] ColBlue  = 16'h001F;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_xy_decode.sv
// Converts the OLED driver's row-major pixel index into registered column/row
// coordinates plus an in-range flag. One cycle of latency.
module pixel_xy_decode
  import game_start_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = ScreenWidth,
  parameter int unsigned HEIGHT = ScreenHeight,
  parameter int unsigned IDX_W  = PixelIdxW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IDX_W-1:0]          pixel_index,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic                      pix_valid
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  logic [XW-1:0] x_d, x_q;
  logic [YW-1:0] y_d, y_q;
  logic          valid_d, valid_q;

  // Row found by comparing against constant row starts; no divider is built.
  always_comb begin
    valid_d = 32'(pixel_index) < WIDTH * HEIGHT;
    y_d     = '0;
    x_d     = XW'(pixel_index);
    for (int unsigned r = 1; r < HEIGHT; r++) begin
      if (32'(pixel_index) >= r * WIDTH) begin
        y_d = YW'(r);
        x_d = XW'(32'(pixel_index) - r * WIDTH);
      end
    end
    if (!valid_d) begin
      x_d = '0;
      y_d = '0;
    end
  end

  // Coordinate output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign pix_valid = valid_q;

endmodule

// File: rtl/game_start_sequencer.sv
// Loading-screen sequencer: decodes pixel coordinates for the renderer, steps
// the loading bar at a fixed frame cadence, holds the full bar, then pulses done.
module game_start_sequencer
  import game_start_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH           = ScreenWidth,
  parameter int unsigned HEIGHT          = ScreenHeight,
  parameter int unsigned NUM_STEPS       = 4,
  parameter int unsigned FRAMES_PER_STEP = 30,
  parameter int unsigned HOLD_FRAMES     = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PixelIdxW-1:0]         pixel_index,
  input  logic                         frame_begin,
  input  logic                         start,
  input  logic                         skip,
  output logic [$clog2(WIDTH)-1:0]     x,
  output logic [$clog2(HEIGHT)-1:0]    y,
  output logic                         pix_valid,
  output logic [$clog2(NUM_STEPS+1)-1:0] cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned FcntMax = max_u(FRAMES_PER_STEP, HOLD_FRAMES);
  localparam int unsigned FW      = (FcntMax > 1) ? $clog2(FcntMax) : 1;
  localparam int unsigned CW      = $clog2(NUM_STEPS + 1);

  seq_state_e    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [FW-1:0] fcnt_d, fcnt_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;

  pixel_xy_decode #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .IDX_W  (PixelIdxW)
  ) u_xy (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_index (pixel_index),
    .x           (x),
    .y           (y),
    .pix_valid   (pix_valid)
  );

  // Next-state logic; busy/done are decoded from the next state so they register
  // alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        fcnt_d = '0;
        // skip is meaningless here; start wins if both arrive together
        if (start) begin
          state_d = StLoad;
          cnt_d   = CW'(1);
        end
      end
      StLoad: begin
        if (skip) begin
          state_d = StDone;
        end else if (frame_begin) begin
          if (fcnt_q == FW'(FRAMES_PER_STEP - 1)) begin
            fcnt_d = '0;
            if (cnt_q < CW'(NUM_STEPS)) begin
              cnt_d = cnt_q + CW'(1);
            end else begin
              state_d = StHold;
            end
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end
      StHold: begin
        if (skip) begin
          state_d = StDone;
        end else if (frame_begin) begin
          if (fcnt_q == FW'(HOLD_FRAMES - 1)) begin
            state_d = StDone;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (state_d == StDone) begin
      cnt_d  = '0;
      fcnt_d = '0;
    end
    busy_d = (state_d == StLoad) || (state_d == StHold);
    done_d = (state_d == StDone);
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
